// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of hazard-detection inputs and pipeline-register
//               control outputs exchanged between the pipeline datapath
//               (master) and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [2:0] ex_dest;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic [1:0] state_o;

  // Datapath side: presents hazard sources, consumes register controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest, ex_mem_read,
           branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, state_o
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest, ex_mem_read,
           branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, state_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 8-bit five-stage core.
//               Generates IF/ID, ID/EX and EX/MEM load/flush/bubble controls:
//               load-use stall, taken-branch flush window of FLUSH_CYCLES
//               unfrozen cycles, and whole-pipeline freeze on mem_busy.
//               Optional macro HAZARD_STATS_EN adds saturating event counters
//               (stall_cnt, flush_cnt, freeze_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  hazard_ctrl_if.slave     bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
  output logic [15:0]      freeze_cnt
`endif
);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_FLUSH  = 2'd1;
  // fcnt preload: the branch cycle itself is the first flush cycle
  localparam logic [1:0] c_FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;

  logic w_hazard;
  logic w_is_stall;
  logic w_is_branch;
  logic w_is_freeze;

  // Load-use hazard: load in EX writes a register the ID instruction reads
  always_comb begin
    w_hazard = bus.ex_mem_read &
               ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_dest)) |
                (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_dest)));
  end

  // Priority decode of outputs and next state: reset, freeze, flush, branch, stall
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.exmem_write = 1'b1;
    state_d         = c_ST_RUN;
    fcnt_d          = 2'd0;
    w_is_stall      = 1'b0;
    w_is_branch     = 1'b0;
    w_is_freeze     = 1'b0;

    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      // Whole pipeline holds; a pending branch is re-presented later
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_write  = 1'b0;
      bus.exmem_write = 1'b0;
      state_d         = state_q;
      fcnt_d          = fcnt_q;
      w_is_freeze     = 1'b1;
    end else if (state_q == c_ST_FLUSH) begin
      // EX holds a bubble here, so hazards and branches are not examined
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      if (fcnt_q <= 2'd1) begin
        state_d = c_ST_RUN;
        fcnt_d  = 2'd0;
      end else begin
        state_d = c_ST_FLUSH;
        fcnt_d  = fcnt_q - 2'd1;
      end
    end else if (bus.branch_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      w_is_branch     = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_d = c_ST_RUN;
        fcnt_d  = 2'd0;
      end else begin
        state_d = c_ST_FLUSH;
        fcnt_d  = c_FCNT_INIT;
      end
    end else if (w_hazard) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      w_is_stall      = 1'b1;
    end
  end

  // State and flush counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Current state is visible for debug and pipeline tracing
  always_comb begin
    bus.state_o = state_q;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] freeze_cnt_q, freeze_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (w_is_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (w_is_branch && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    if (w_is_freeze && (freeze_cnt_q != 16'hFFFF)) begin
      freeze_cnt_d = freeze_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 16'd0;
      flush_cnt_q  <= 16'd0;
      freeze_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Bench for hazard_ctrl. Three instances (FLUSH_CYCLES = 1,2,3)
//               share one stimulus stream; each is compared every cycle with
//               a model that tracks the number of flush cycles still owed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, ex_dest;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model state: unfrozen flush cycles still owed after the current one
  int rem [3];
`ifdef HAZARD_STATS_EN
  int m_stall [3];
  int m_flush [3];
  int m_freeze[3];
  logic [15:0] s_stall [3];
  logic [15:0] s_flush [3];
  logic [15:0] s_freeze[3];
`endif

  // Observed vector: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, state_o}
  logic [7:0] obs [3];

  always #5 clk = ~clk;

  hazard_ctrl_if hif [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hif[g].id_rs1       = id_rs1;
    assign hif[g].id_rs2       = id_rs2;
    assign hif[g].id_uses_rs1  = id_uses_rs1;
    assign hif[g].id_uses_rs2  = id_uses_rs2;
    assign hif[g].ex_dest      = ex_dest;
    assign hif[g].ex_mem_read  = ex_mem_read;
    assign hif[g].branch_taken = branch_taken;
    assign hif[g].mem_busy     = mem_busy;
    assign obs[g] = {hif[g].pc_write, hif[g].ifid_write, hif[g].ifid_flush,
                     hif[g].idex_write, hif[g].idex_bubble, hif[g].exmem_write,
                     hif[g].state_o};
    hazard_ctrl #(.FLUSH_CYCLES(g + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (hif[g])
`ifdef HAZARD_STATS_EN
      ,
      .stall_cnt  (s_stall[g]),
      .flush_cnt  (s_flush[g]),
      .freeze_cnt (s_freeze[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic load_use();
    return ex_mem_read && ((id_uses_rs1 && (id_rs1 == ex_dest)) ||
                           (id_uses_rs2 && (id_rs2 == ex_dest)));
  endfunction

  function automatic logic [7:0] model_out(int g);
    logic [1:0] st;
    st = (rem[g] > 0) ? 2'd1 : 2'd0;
    if (rst)                         return {6'b011111, st};
    if (mem_busy)                    return {6'b000000, st};
    if (rem[g] > 0 || branch_taken)  return {6'b111111, st};
    if (load_use())                  return {6'b000111, st};
    return {6'b110101, st};
  endfunction

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Compare every instance with the model mid-cycle
  task automatic at_neg(input string tag);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_fc%0d", tag, g + 1), {8'h00, obs[g]}, {8'h00, model_out(g)});
`ifdef HAZARD_STATS_EN
      chk($sformatf("%s_stall%0d", tag, g + 1), s_stall[g], 16'(m_stall[g]));
      chk($sformatf("%s_flush%0d", tag, g + 1), s_flush[g], 16'(m_flush[g]));
      chk($sformatf("%s_frz%0d", tag, g + 1), s_freeze[g], 16'(m_freeze[g]));
`endif
    end
  endtask

  // Advance one clock and the model with it
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < 3; g++) begin
`ifdef HAZARD_STATS_EN
      if (rst) begin
        m_stall[g] = 0; m_flush[g] = 0; m_freeze[g] = 0;
      end else if (mem_busy)          m_freeze[g] = sat_inc(m_freeze[g]);
      else if (rem[g] > 0) ;
      else if (branch_taken)          m_flush[g] = sat_inc(m_flush[g]);
      else if (load_use())            m_stall[g] = sat_inc(m_stall[g]);
`endif
      if (rst)                rem[g] = 0;
      else if (mem_busy)      rem[g] = rem[g];
      else if (rem[g] > 0)    rem[g] = rem[g] - 1;
      else if (branch_taken)  rem[g] = g;  // FLUSH_CYCLES - 1
      else                    rem[g] = 0;
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_dest = 3'd7;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rem[g] = 0;
`ifdef HAZARD_STATS_EN
      m_stall[g] = 0; m_flush[g] = 0; m_freeze[g] = 0;
`endif
    end
    idle();
    rst = 1'b1;
    #1;
    tick();
    at_neg("reset");
    chk("reset_out", {8'h00, obs[2]}, 16'h007C);
    tick();
    rst = 1'b0;

    // Load-use stall lasts one cycle
    ex_mem_read = 1'b1; ex_dest = 3'd3; id_rs2 = 3'd3; id_uses_rs2 = 1'b1;
    at_neg("lu0");
    chk("lu_c0", {8'h00, obs[0]}, 16'h001C);
    tick();
    ex_mem_read = 1'b0;
    at_neg("lu1");
    chk("lu_c1", {8'h00, obs[0]}, 16'h00D4);
    tick();

    // Taken branch; hazard during flush cycle is ignored for FLUSH_CYCLES=2
    branch_taken = 1'b1;
    at_neg("br0");
    chk("br_c0", {8'h00, obs[1]}, 16'h00FC);
    tick();
    branch_taken = 1'b0; ex_mem_read = 1'b1;
    at_neg("br1");
    chk("br_c1", {8'h00, obs[1]}, 16'h00FD);
    tick();
    idle();
    at_neg("br2");
    tick();
    at_neg("br3");
    chk("br_c3", {8'h00, obs[1]}, 16'h00D4);
    tick();

    // Freeze right after branch, FLUSH_CYCLES=3: 5 cycles branch-to-RUN
    branch_taken = 1'b1;
    at_neg("fz0");
    tick();
    branch_taken = 1'b0; mem_busy = 1'b1;
    at_neg("fz1");
    chk("fz_c1", {8'h00, obs[2]}, 16'h0001);
    tick();
    at_neg("fz2");
    tick();
    mem_busy = 1'b0;
    at_neg("fz3");
    chk("fz_c3", {8'h00, obs[2]}, 16'h00FD);
    tick();
    at_neg("fz4");
    chk("fz_c4", {8'h00, obs[2]}, 16'h00FD);
    tick();
    at_neg("fz5");
    chk("fz_c5", {8'h00, obs[2]}, 16'h00D4);
    tick();

    // Branch together with load-use: freeze first, then branch wins
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dest = 3'd5;
    id_rs1 = 3'd5; id_uses_rs1 = 1'b1; mem_busy = 1'b1;
    at_neg("sim0");
    chk("sim_freeze", {8'h00, obs[0]}, 16'h0000);
    tick();
    mem_busy = 1'b0;
    at_neg("sim1");
    chk("sim_branch", {8'h00, obs[0]}, 16'h00FC);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      at_neg("drain");
      tick();
    end

    // Reset in second flush cycle, FLUSH_CYCLES=3
    branch_taken = 1'b1;
    at_neg("rf0");
    tick();
    branch_taken = 1'b0; rst = 1'b1;
    at_neg("rf1");
    chk("rf_c1", {8'h00, obs[2]}, 16'h007D);
    tick();
    rst = 1'b0;
    at_neg("rf2");
    chk("rf_c2", {8'h00, obs[2]}, 16'h00D4);
    tick();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      mem_busy     = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      id_uses_rs1  = $urandom_range(0, 1) == 1;
      id_uses_rs2  = $urandom_range(0, 1) == 1;
      id_rs1       = 3'($urandom_range(0, 3));
      id_rs2       = 3'($urandom_range(0, 3));
      ex_dest      = 3'($urandom_range(0, 3));
      at_neg("rand");
      tick();
    end
    idle();
    rst = 1'b0;

`ifdef HAZARD_STATS_EN
    // Three load-use stalls after reset, then saturate the freeze counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_mem_read = 1'b1; ex_dest = 3'd0; id_rs1 = 3'd0; id_uses_rs1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_mem_read = 1'b0;
      tick();
      ex_mem_read = 1'b1;
    end
    idle();
    at_neg("st3");
    chk("stall3", s_stall[0], 16'd3);
    mem_busy = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    mem_busy = 1'b0;
    at_neg("sat");
    chk("freeze_sat", s_freeze[1], 16'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg("st_rst");
    chk("stats_rst", s_stall[0] | s_flush[0] | s_freeze[0], 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
